wb_gpio_ctrl: RTL

- Parametrised Wishbone GPIO controller for the picosoc interconnect; one instance replaces the GPIO block and the software FPGA-reset register.
- Provides N_GPIO bidirectional channels with output-enable and atomic set/clear.
- Provides rising/falling edge capture with a level interrupt and a keyed, fixed-length reset pulse.
- Board-level wiring is the same as today: gpio_o[0] drives the LED, reset_out feeds the fpga_reset logic.

---
 rtl/gpio_ctrl_pkg.sv | 31 +++
 rtl/gpio_debounce.sv | 33 +++
 rtl/wb_gpio_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/gpio_ctrl_pkg.sv
// gpio_ctrl_pkg: register map, reset-pulse FSM encoding and parameter checks
// shared by the Wishbone GPIO controller and its debounce channels.
package gpio_ctrl_pkg;

    localparam logic [3:0] REG_IN       = 4'd0;
    localparam logic [3:0] REG_OUT      = 4'd1;
    localparam logic [3:0] REG_OE       = 4'd2;
    localparam logic [3:0] REG_SET      = 4'd3;
    localparam logic [3:0] REG_CLR      = 4'd4;
    localparam logic [3:0] REG_RISE_EN  = 4'd5;
    localparam logic [3:0] REG_FALL_EN  = 4'd6;
    localparam logic [3:0] REG_STATUS   = 4'd7;
    localparam logic [3:0] REG_RST_CTRL = 4'd8;
    localparam logic [3:0] REG_DEBOUNCE = 4'd9;

    typedef enum logic {
        RST_IDLE  = 1'b0,
        RST_PULSE = 1'b1
    } rst_state_e;

    function automatic bit cfg_ok(int n_gpio, int sync_stages, int reset_pulse);
        return (n_gpio >= 1) && (n_gpio <= 32) &&
               (sync_stages >= 2) && (sync_stages <= 4) &&
               (reset_pulse >= 1) && (reset_pulse <= 65535);
    endfunction

    function automatic logic [31:0] sel_mask(logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: one channel; IN follows the input only after three
// consecutive prescaler ticks sample the same level.
module gpio_debounce
    import gpio_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic tick_i,
    input  logic d_i,
    output logic q_o
);

    logic [2:0] hist_q;
    logic [2:0] hist_d;
    logic       q_q;

    assign hist_d = {hist_q[1:0], d_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q <= '0;
            q_q    <= 1'b0;
        end else if (tick_i) begin
            hist_q <= hist_d;
            if ((&hist_d) || (~|hist_d)) begin
                q_q <= d_i;
            end
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/wb_gpio_ctrl.sv
// wb_gpio_ctrl: Wishbone GPIO with set/clear, edge capture IRQ and keyed
// reset pulse. Define GPIO_DEBOUNCE_EN to add per-channel input debounce.
module wb_gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int unsigned N_GPIO             = 16,
    parameter logic [31:0] OUT_RESET          = 32'h0,
    parameter logic [31:0] OE_RESET           = 32'h0,
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned RESET_PULSE        = 16,
    parameter logic [15:0] RESET_KEY          = 16'hB007,
    parameter logic [15:0] DEBOUNCE_DIV_RESET = 16'd4799
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    input  logic              wb_we_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    input  logic [N_GPIO-1:0] gpio_i,
    output logic [N_GPIO-1:0] gpio_o,
    output logic [N_GPIO-1:0] gpio_oe,
    output logic              irq_o,
    output logic              reset_out
);

    localparam logic [15:0] PULSE_LAST = 16'(RESET_PULSE - 1);

    if (!cfg_ok(N_GPIO, SYNC_STAGES, RESET_PULSE)) begin : g_cfg_err
        $error("wb_gpio_ctrl: parameter out of range");
    end

    logic [N_GPIO-1:0] sync_q [SYNC_STAGES];
    logic [N_GPIO-1:0] in_w, prev_q, edge_ev;
    logic [N_GPIO-1:0] out_q, out_d, oe_q, oe_d;
    logic [N_GPIO-1:0] rise_q, rise_d, fall_q, fall_d;
    logic [N_GPIO-1:0] stat_q, stat_d;
    logic [N_GPIO-1:0] wmask, wdata;
    logic [31:0]       bmask, rdata, dat_q;
    logic [15:0]       div_rd;
    logic [3:0]        idx;
    logic              access, wr, key_wr, div_wr;
    logic              ack_q, irq_q;
    rst_state_e        rst_state_q;
    logic [15:0]       rst_cnt_q;
    logic              rst_out_q;
    logic              unused_bits;

    assign access = wb_cyc_i & wb_stb_i & ~ack_q;
    assign wr     = access & wb_we_i;
    assign idx    = wb_adr_i[5:2];
    assign bmask  = sel_mask(wb_sel_i);
    assign wmask  = bmask[N_GPIO-1:0];
    assign wdata  = wb_dat_i[N_GPIO-1:0] & wmask;
    assign key_wr = wr && (idx == REG_RST_CTRL) &&
                    (wb_dat_i[15:0] == RESET_KEY) && (wb_sel_i[1:0] == 2'b11);
    assign div_wr = wr && (idx == REG_DEBOUNCE);

    assign unused_bits = ^{wb_adr_i[31:6], wb_adr_i[1:0], bmask, wb_dat_i};

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= in_w;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    logic [15:0] div_q, presc_q;
    logic        tick;

    assign tick   = (presc_q == div_q);
    assign div_rd = div_q;

    // A divider write restarts the prescaler so the new period starts cleanly
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            div_q   <= DEBOUNCE_DIV_RESET;
            presc_q <= '0;
        end else if (div_wr) begin
            div_q   <= (div_q & ~bmask[15:0]) | (wb_dat_i[15:0] & bmask[15:0]);
            presc_q <= '0;
        end else begin
            presc_q <= tick ? 16'd0 : presc_q + 16'd1;
        end
    end

    for (genvar g = 0; g < N_GPIO; g++) begin : g_db
        gpio_debounce u_db (
            .clk_i  (wb_clk_i),
            .rst_i  (wb_rst_i),
            .tick_i (tick),
            .d_i    (sync_q[SYNC_STAGES-1][g]),
            .q_o    (in_w[g])
        );
    end
`else
    logic unused_div;

    assign in_w       = sync_q[SYNC_STAGES-1];
    assign div_rd     = '0;
    assign unused_div = div_wr;
`endif

    assign edge_ev = (in_w & ~prev_q & rise_q) | (~in_w & prev_q & fall_q);

    always_comb begin
        out_d  = out_q;
        oe_d   = oe_q;
        rise_d = rise_q;
        fall_d = fall_q;
        stat_d = stat_q;
        if (wr) begin
            case (idx)
                REG_OUT:     out_d  = (out_q & ~wmask) | wdata;
                REG_OE:      oe_d   = (oe_q & ~wmask) | wdata;
                REG_SET:     out_d  = out_q | wdata;
                REG_CLR:     out_d  = out_q & ~wdata;
                REG_RISE_EN: rise_d = (rise_q & ~wmask) | wdata;
                REG_FALL_EN: fall_d = (fall_q & ~wmask) | wdata;
                REG_STATUS:  stat_d = stat_q & ~wdata;
                default:     ;
            endcase
        end
        // A fresh event beats a same-cycle clear so no edge is lost
        stat_d = stat_d | edge_ev;
    end

    always_comb begin
        rdata = '0;
        case (idx)
            REG_IN:       rdata = 32'(in_w);
            REG_OUT:      rdata = 32'(out_q);
            REG_OE:       rdata = 32'(oe_q);
            REG_RISE_EN:  rdata = 32'(rise_q);
            REG_FALL_EN:  rdata = 32'(fall_q);
            REG_STATUS:   rdata = 32'(stat_q);
            REG_RST_CTRL: rdata = {31'd0, rst_out_q};
            REG_DEBOUNCE: rdata = 32'(div_rd);
            default:      rdata = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            out_q  <= OUT_RESET[N_GPIO-1:0];
            oe_q   <= OE_RESET[N_GPIO-1:0];
            rise_q <= '0;
            fall_q <= '0;
            stat_q <= '0;
            ack_q  <= 1'b0;
            dat_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            oe_q   <= oe_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            stat_q <= stat_d;
            ack_q  <= access;
            dat_q  <= (access && !wb_we_i) ? rdata : 32'd0;
            irq_q  <= |stat_q;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rst_state_q <= RST_IDLE;
            rst_cnt_q   <= '0;
            rst_out_q   <= 1'b0;
        end else begin
            case (rst_state_q)
                RST_IDLE: begin
                    if (key_wr) begin
                        rst_state_q <= RST_PULSE;
                        rst_cnt_q   <= PULSE_LAST;
                        rst_out_q   <= 1'b1;
                    end
                end
                RST_PULSE: begin
                    if (rst_cnt_q == 16'd0) begin
                        rst_state_q <= RST_IDLE;
                        rst_out_q   <= 1'b0;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - 16'd1;
                    end
                end
                default: rst_state_q <= RST_IDLE;
            endcase
        end
    end

    assign wb_dat_o  = dat_q;
    assign wb_ack_o  = ack_q;
    assign gpio_o    = out_q;
    assign gpio_oe   = oe_q;
    assign irq_o     = irq_q;
    assign reset_out = rst_out_q;

endmodule
